// File: rtl/trena_pkg.sv
// Shared definitions for the trena measurement-frame receiver:
// state codes, default framing bytes and the ASCII digit range.
package trena_pkg;

  typedef enum logic [3:0] {
    ESPERA = 4'd0,
    DIG_C  = 4'd1,
    DIG_D  = 4'd2,
    DIG_U  = 4'd3,
    TERM   = 4'd4,
    VALIDA = 4'd5,
    ERRO   = 4'd6
  } estado_t;

  localparam logic [7:0] CHAR_ALERTA_PADRAO = 8'h21;
  localparam logic [7:0] CHAR_FIM_PADRAO    = 8'h23;
  localparam logic [7:0] ASCII_ZERO         = 8'h30;
  localparam logic [7:0] ASCII_NOVE         = 8'h39;

  function automatic logic eh_digito(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NOVE);
  endfunction

endpackage

// File: rtl/trena_contador_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags fim
// once TIMEOUT-1 is reached; holds there until cleared.
module trena_contador_timeout #(
  parameter int TIMEOUT = 5_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic habilita,
  output logic fim
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      contagem <= '0;
    end else if (habilita && (contagem != LIMITE)) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim = habilita && (contagem == LIMITE);

endmodule

// File: rtl/trena_recepcao_medida.sv
// Parses "[!]DDD#" measurement frames from the UART byte stream into a held
// BCD distance and alert flag, pulsing medida_pronta on success or erro on failure.
module trena_recepcao_medida
  import trena_pkg::*;
#(
  parameter int         TIMEOUT     = 5_000_000,
  parameter logic [7:0] CHAR_ALERTA = CHAR_ALERTA_PADRAO,
  parameter logic [7:0] CHAR_FIM    = CHAR_FIM_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  dado_rx,
  input  logic        pronto_rx,
  output logic [11:0] medida,
  output logic        alerta,
  output logic        medida_pronta,
  output logic        erro,
  output logic [3:0]  db_estado
);

  estado_t    estado;
  logic [3:0] centena_tmp;
  logic [3:0] dezena_tmp;
  logic [3:0] unidade_tmp;
  logic       alerta_tmp;
  logic       dentro_quadro;
  logic       fim_timeout;
  logic       digito;

  assign digito        = eh_digito(dado_rx);
  assign dentro_quadro = (estado == DIG_C) || (estado == DIG_D) ||
                         (estado == DIG_U) || (estado == TERM);

  // Leaving the in-frame states always disables the counter, which clears it.
  trena_contador_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .limpa    (pronto_rx || !dentro_quadro),
    .habilita (dentro_quadro),
    .fim      (fim_timeout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= ESPERA;
      medida        <= 12'h000;
      alerta        <= 1'b0;
      medida_pronta <= 1'b0;
      erro          <= 1'b0;
      centena_tmp   <= 4'h0;
      dezena_tmp    <= 4'h0;
      unidade_tmp   <= 4'h0;
      alerta_tmp    <= 1'b0;
    end else begin
      medida_pronta <= 1'b0;
      erro          <= 1'b0;
      case (estado)
        ESPERA: begin
          if (pronto_rx && (dado_rx == CHAR_ALERTA)) begin
            alerta_tmp <= 1'b1;
            estado     <= DIG_C;
          end else if (pronto_rx && digito) begin
            centena_tmp <= dado_rx[3:0];
            alerta_tmp  <= 1'b0;
            estado      <= DIG_D;
          end
        end
        DIG_C, DIG_D, DIG_U: begin
          if (pronto_rx && digito) begin
            case (estado)
              DIG_C:   begin centena_tmp <= dado_rx[3:0]; estado <= DIG_D; end
              DIG_D:   begin dezena_tmp  <= dado_rx[3:0]; estado <= DIG_U; end
              default: begin unidade_tmp <= dado_rx[3:0]; estado <= TERM;  end
            endcase
          end else if (pronto_rx || fim_timeout) begin
            estado <= ERRO;
            erro   <= 1'b1;
          end
        end
        TERM: begin
          // Outputs are loaded on entry to VALIDA so they appear with the pulse.
          if (pronto_rx && (dado_rx == CHAR_FIM)) begin
            estado        <= VALIDA;
            medida        <= {centena_tmp, dezena_tmp, unidade_tmp};
            alerta        <= alerta_tmp;
            medida_pronta <= 1'b1;
          end else if (pronto_rx || fim_timeout) begin
            estado <= ERRO;
            erro   <= 1'b1;
          end
        end
        VALIDA:  estado <= ESPERA;
        ERRO:    estado <= ESPERA;
        default: estado <= ESPERA;
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: doc/trena_recepcao_medida.md
Name: trena_recepcao_medida

Overview:
- Receive side of the trena serial link: consumes bytes from the UART receiver and parses the measurement frame the trena control unit emits.
- Frame format: optional alert prefix '!' (0x21), three ASCII digits (hundreds, tens, units, 0x30-0x39), then terminator '#' (0x23).
- Presents the decoded distance as 3-digit BCD plus the alert flag, with a completion strobe. Malformed or stalled frames raise an error strobe.
- Sits between uart_rx and the display/host logic on the monitoring board.

Parameters:
- TIMEOUT, 5_000_000, max clock cycles allowed between consecutive bytes inside a frame (100 ms at 50 MHz).
- CHAR_ALERTA, 8'h21, alert prefix byte.
- CHAR_FIM, 8'h23, frame terminator byte.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- dado_rx  in  8  received byte; valid only when pronto_rx=1.
- pronto_rx  in  1  one-cycle strobe, one per received byte.
- medida  out  12  BCD distance {centena,dezena,unidade}; holds the last valid frame.
- alerta  out  1  alert flag of the last valid frame; held.
- medida_pronta  out  1  one-cycle pulse when medida/alerta update.
- erro  out  1  one-cycle pulse on malformed frame or timeout.
- db_estado  out  4  current state encoding, for debug.

Behaviour:
- Reset (synchronous, active-high): state ESPERA; medida=12'h000, alerta=0, medida_pronta=0, erro=0; shadow registers and timeout counter cleared. Reset mid-frame discards the partial frame with no erro pulse.
- Registered FSM; all outputs derive from registered state/registers. db_estado = state code.
- ESPERA (0):
  - On pronto_rx with CHAR_ALERTA: alerta_tmp=1, go to DIG_C.
  - On pronto_rx with a digit: centena_tmp=digit-0x30, alerta_tmp=0, go to DIG_D.
  - Any other byte is ignored: stay in ESPERA, no erro.
- DIG_C (1): a digit stores centena_tmp and goes to DIG_D. Any other byte, including a second '!', goes to ERRO.
- DIG_D (2): a digit stores dezena_tmp and goes to DIG_U. A non-digit goes to ERRO.
- DIG_U (3): a digit stores unidade_tmp and goes to TERM. A non-digit goes to ERRO.
- TERM (4): CHAR_FIM goes to VALIDA. Any other byte goes to ERRO.
- VALIDA (5): copies the shadow registers to medida/alerta; medida_pronta=1 for exactly this cycle; next state ESPERA.
- ERRO (6): erro=1 for exactly this cycle; medida/alerta unchanged; next state ESPERA.
- Latency: medida_pronta is asserted 1 cycle after the cycle in which the '#' strobe is sampled. New medida is visible the same cycle medida_pronta=1.
- Timeout:
  - Counter runs in DIG_C..TERM and clears on every pronto_rx and on any state change.
  - When it reaches TIMEOUT-1 without pronto_rx, go to ERRO.
  - A pronto_rx in that same cycle takes priority: the byte is processed and the counter clears.
  - Counter width is $clog2(TIMEOUT). It never wraps, because it is cleared on entry to ERRO.
- A pronto_rx arriving in VALIDA or ERRO is dropped. UART byte spacing is far above 1 cycle, so no loss occurs in practice.
- Digit test: 0x30 <= byte <= 0x39. BCD nibble = byte[3:0].
- Frame-to-frame: a '!' or digit arriving right after VALIDA/ERRO, once back in ESPERA, starts a new frame normally.

Decomposition:
- Package trena_pkg holds:
  - state codes: ESPERA=0, DIG_C=1, DIG_D=2, DIG_U=3, TERM=4, VALIDA=5, ERRO=6;
  - CHAR_ALERTA and CHAR_FIM defaults;
  - ASCII digit bounds.
- One natural sub-module: trena_contador_timeout (counter with clear, enable, and fim output at TIMEOUT-1).
- The FSM and datapath stay in trena_recepcao_medida.

Test Plan:
- Frame "1","2","3","#" -> 1 cycle after the '#' strobe: medida=12'h123, alerta=0, medida_pronta pulses 1 cycle, erro=0.
- Frame "!","0","4","7","#" -> medida=12'h047, alerta=1, medida_pronta pulse. A following frame "0","0","5","#" -> medida=12'h005, alerta=0.
- Frame "1","A","3","#" -> erro pulses 1 cycle after 'A'; medida keeps its previous value; subsequent "2","2","2","#" -> medida=12'h222.
- Frame "9","8","7","X" -> erro pulse, no medida_pronta. Leading garbage 0x0D,0x0A then "5","5","5","#" -> medida=12'h555 with no erro.
- TIMEOUT=100 (override): send "1","2", then idle for 100 cycles -> erro pulses exactly at cycle 100 after the '2' strobe. With a byte arriving at cycle 99 -> no erro.
- Assert reset for 1 cycle after "!","3" -> state ESPERA, db_estado=0, medida/alerta cleared to 0, no erro. Next "3","1","4","#" -> medida=12'h314, alerta=0.
